// File: rtl/logit_pkg.sv
// Shared constants for the logit (inverse sigmoid) decoder: Q-format widths,
// pipeline latency and the 255-entry threshold ROM, built at elaboration.
package logit_pkg;

  localparam int unsigned Y_W       = 16;
  localparam int unsigned X_W       = 8;
  localparam int unsigned X_FRAC    = 5;
  localparam int unsigned LATENCY   = 8;
  localparam int unsigned LEVELS    = 256;
  localparam int unsigned T_ENTRIES = 255;

  // Fixed-point precision used only while building the table.
  localparam int unsigned EXP_FRAC  = 60;
  localparam int unsigned CALC_W    = 128;
  localparam int unsigned SERIES_N  = 24;

  typedef logic [T_ENTRIES-1:0][Y_W-1:0] t_rom_t;
  typedef logic [LEVELS-1:0][Y_W-1:0]    s_tab_t;

  // S(k) = round(65536*sigmoid(k/32)) for k=-128..127, index k+128.
  // exp(1/32) is summed as a Taylor series, then exp(m/32) is built by
  // repeated multiplication; 60 fractional bits keep the rounding exact.
  function automatic s_tab_t build_s_tab();
    logic [CALC_W-1:0] one;
    logic [CALC_W-1:0] term;
    logic [CALC_W-1:0] step;
    logic [CALC_W-1:0] e;
    logic [CALC_W-1:0] den;
    logic [CALC_W-1:0] s;
    s_tab_t            tab;
    one  = CALC_W'(1) << EXP_FRAC;
    step = one;
    term = one;
    for (int n = 1; n <= int'(SERIES_N); n++) begin
      term = term / CALC_W'((1 << X_FRAC) * n);
      step = step + term;
    end
    tab = '0;
    e   = one;
    for (int m = 0; m <= 128; m++) begin
      if (m > 0) begin
        e = (e * step) >> EXP_FRAC;
      end
      den = e + one;
      if (m <= 127) begin
        s = ((e << (Y_W + 1)) + den) / (den << 1);
        tab[128 + m] = (s > CALC_W'(16'hFFFF)) ? 16'hFFFF : Y_W'(s);
      end
      if (m >= 1) begin
        s = ((one << (Y_W + 1)) + den) / (den << 1);
        tab[128 - m] = (s > CALC_W'(16'hFFFF)) ? 16'hFFFF : Y_W'(s);
      end
    end
    return tab;
  endfunction

  // T(k) = ceil((S(k-1)+S(k))/2) for k=-127..127, index k+127.
  function automatic t_rom_t build_t_rom();
    s_tab_t s_tab;
    t_rom_t rom;
    s_tab = build_s_tab();
    rom   = '0;
    for (int i = 0; i < int'(T_ENTRIES); i++) begin
      rom[i] = Y_W'((17'(s_tab[i]) + 17'(s_tab[i + 1]) + 17'd1) >> 1);
    end
    return rom;
  endfunction

  localparam t_rom_t T_ROM = build_t_rom();

endpackage

// File: rtl/logit_stage.sv
// One binary-search step: resolves one bit of the level index by comparing
// the carried sample against the threshold picked by the bits resolved so far.
module logit_stage
  import logit_pkg::*;
#(
  parameter int unsigned STAGE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic [Y_W-1:0] i_y,
  input  logic [X_W-1:0] i_acc,
  output logic           o_valid,
  output logic [Y_W-1:0] o_y,
  output logic [X_W-1:0] o_acc
);

  // Bit of the offset-binary level index decided by this stage.
  localparam logic [X_W-1:0] STAGE_BIT = X_W'(1) << (X_W - 1 - STAGE);

  logic [X_W-1:0] w_cand;
  logic [X_W-1:0] w_idx;
  logic           w_hit;
  logic [X_W-1:0] w_acc_next;

  logic           r_valid;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] r_acc;

  // Candidate level u means "T(u-128) satisfied", which sits at ROM index u-1.
  always_comb begin
    w_cand     = i_acc | STAGE_BIT;
    w_idx      = w_cand - X_W'(1);
    w_hit      = (i_y >= T_ROM[w_idx]);
    w_acc_next = w_hit ? w_cand : i_acc;
  end

  // Stage register; payload only loads on valid so idle inputs are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_acc   <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_y   <= i_y;
        r_acc <= w_acc_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_y     = r_y;
  assign o_acc   = r_acc;

endmodule

// File: rtl/logit.sv
// Inverse sigmoid decoder: Q0.16 sigmoid value in, nearest Q3.5 argument out,
// via an 8-stage pipelined binary search over the threshold ROM.
module logit
  import logit_pkg::*;
#(
  parameter logic [50:0] NUMBER = 51'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_y,
  input  logic        i_in_valid,
  output logic        o_out_valid,
  output logic [7:0]  o_x,
  output logic [50:0] number
);

  logic           w_valid [0:LATENCY];
  logic [Y_W-1:0] w_y     [0:LATENCY];
  logic [X_W-1:0] w_acc   [0:LATENCY];

  logic           r_out_valid;
  logic [X_W-1:0] r_x;

  assign w_valid[0] = i_in_valid;
  assign w_y[0]     = i_y;
  assign w_acc[0]   = '0;

  // Search chain; stage s decides level-index bit 7-s.
  for (genvar s = 0; s < int'(LATENCY); s++) begin : g_stage
    logic_stage_wrap_guard: begin end
  end

  for (genvar s = 0; s < int'(LATENCY); s++) begin : g_search
    logit_stage #(
      .STAGE (s)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid[s]),
      .i_y     (w_y[s]),
      .i_acc   (w_acc[s]),
      .o_valid (w_valid[s + 1]),
      .o_y     (w_y[s + 1]),
      .o_acc   (w_acc[s + 1])
    );
  end

  // Output register: level index u maps to x = u-128; holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_x         <= '0;
    end else begin
      r_out_valid <= w_valid[LATENCY];
      if (w_valid[LATENCY]) begin
        r_x <= w_acc[LATENCY] ^ X_W'(8'h80);
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_x         = r_x;
  assign number      = NUMBER;

endmodule

// File: tb/tb_logit.sv
// Self-checking bench for logit: directed, boundary, round-trip, bubble,
// reset and random traffic against a real-arithmetic sigmoid model.
module tb_logit;

  localparam logic [50:0] NUM_VAL = 51'd4242;

  logic        clk;
  logic        rst;
  logic [15:0] i_y;
  logic        i_in_valid;
  logic        o_out_valid;
  logic [7:0]  o_x;
  logic [50:0] number;

  int checks   = 0;
  int failures = 0;

  int s_arr [0:255];   // S(k) at index k+128
  int t_arr [0:254];   // T(k) at index k+127

  logic       pv [0:7];
  logic [7:0] px [0:7];
  logic       mv;
  logic [7:0] mx;
  logic [7:0] sq [$];

  logit #(
    .NUMBER (NUM_VAL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_y         (i_y),
    .i_in_valid  (i_in_valid),
    .o_out_valid (o_out_valid),
    .o_x         (o_x),
    .number      (number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sig_level(int k);
    real v;
    int  r;
    v = 65536.0 / (1.0 + $exp(-real'(k) / 32.0));
    r = int'($floor(v + 0.5));
    if (r > 65535) r = 65535;
    return r;
  endfunction

  // Largest k with y >= T(k), else -128.
  function automatic int ref_x(int y);
    int res;
    res = -128;
    for (int k = -127; k <= 127; k++) begin
      if (y >= t_arr[k + 127]) res = k;
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the delay-line model, then check on the falling edge.
  task automatic cycle(input logic v, input logic [15:0] y, input logic r);
    logic       ov;
    logic [7:0] ox;
    logic [7:0] e;
    rst        = r;
    i_in_valid = v;
    i_y        = v ? y : 16'hxxxx;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        pv[i] = 1'b0;
        px[i] = 8'h00;
      end
      mv = 1'b0;
      mx = 8'h00;
    end else begin
      ov = pv[7];
      ox = px[7];
      for (int i = 7; i > 0; i--) begin
        pv[i] = pv[i - 1];
        px[i] = px[i - 1];
      end
      pv[0] = v;
      px[0] = v ? 8'(ref_x(int'(y))) : 8'h00;
      mv = ov;
      if (ov) mx = ox;
    end
    @(negedge clk);
    chk("out_valid", 64'(o_out_valid), 64'(mv));
    chk("out_x", 64'(o_x), 64'(mx));
    if (o_out_valid === 1'b1 && sq.size() > 0) begin
      e = sq.pop_front();
      chk("spec_x", 64'(o_x), 64'(e));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic directed(input logic [15:0] y, input logic [7:0] e);
    sq.push_back(e);
    cycle(1'b1, y, 1'b0);
    idle(8);
  endtask

  initial begin
    for (int k = -128; k <= 127; k++) s_arr[k + 128] = sig_level(k);
    for (int k = -127; k <= 127; k++)
      t_arr[k + 127] = (s_arr[k + 127] + s_arr[k + 128] + 1) / 2;
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      px[i] = 8'h00;
    end
    mv = 1'b0;
    mx = 8'h00;

    // Reset state and constant port.
    cycle(1'b1, 16'h1234, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("number", 64'(number), 64'(NUM_VAL));
    idle(3);

    // Directed decode points and saturation.
    directed(16'd32768, 8'h00);
    directed(16'd33024, 8'h01);
    directed(16'd33023, 8'h00);
    directed(16'd32512, 8'h00);
    directed(16'd32511, 8'hFF);
    directed(16'd0,     8'h80);
    directed(16'd65535, 8'h7F);

    // Round trip: every golden level back-to-back.
    for (int k = -128; k <= 127; k++) begin
      sq.push_back(8'(k));
      cycle(1'b1, 16'(s_arr[k + 128]), 1'b0);
    end
    idle(9);

    // Bubble pattern 1,0,1,1,0.
    cycle(1'b1, 16'd40000, 1'b0);
    cycle(1'b0, 16'd0,     1'b0);
    cycle(1'b1, 16'd20000, 1'b0);
    cycle(1'b1, 16'd50000, 1'b0);
    cycle(1'b0, 16'd0,     1'b0);
    idle(10);

    // Reset mid-stream: four samples in flight are dropped.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(10000 * (i + 2)), 1'b0);
    cycle(1'b1, 16'd30000, 1'b1);
    chk("rst_valid", 64'(o_out_valid), 64'd0);
    chk("rst_x", 64'(o_x), 64'd0);
    idle(12);
    chk("number_after_rst", 64'(number), 64'(NUM_VAL));

    // Every threshold edge: T(k) -> k, T(k)-1 -> k-1.
    for (int k = -127; k <= 127; k++) begin
      sq.push_back(8'(k));
      cycle(1'b1, 16'(t_arr[k + 127]), 1'b0);
      sq.push_back(8'(k - 1));
      cycle(1'b1, 16'(t_arr[k + 127] - 1), 1'b0);
    end
    idle(9);
    chk("spec_queue_drained", 64'(sq.size()), 64'd0);

    // Random traffic with random bubbles.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] y;
      logic        v;
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       y = 16'h0000;
        1:       y = 16'hFFFF;
        2:       y = 16'(t_arr[$urandom_range(0, 254)]);
        default: y = 16'($urandom);
      endcase
      cycle(v, y, 1'b0);
    end
    idle(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
